// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed A/D bus sequencer.
// The verify states exist only when RTC_READBACK_VERIFY_EN is defined.
package rtc_bus_pkg;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  localparam int DEF_N_ENTRIES = 16;
  localparam int DEF_T_PULSE   = 7;
  localparam int DEF_T_GAP     = 7;
  localparam int DEF_DATA_W    = 8;

  // Addresses at or above this are command bytes and are never read back.
  localparam logic [7:0] CMD_ADDR_MIN = 8'hF0;

  typedef struct packed {
    logic       op;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_GAP,
    S_DATA,
    S_DATA_GAP,
`ifdef RTC_READBACK_VERIFY_EN
    S_VERIFY_ADDR,
    S_VERIFY_AGAP,
    S_VERIFY_DATA,
    S_VERIFY_DGAP,
`endif
    S_FINISH
  } state_t;

  function automatic entry_t mk_entry(input logic op, input logic [7:0] addr,
                                      input logic [7:0] data);
    entry_t e;
    e.op   = op;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic logic needs_verify(input entry_t e);
    return (e.op == OP_WR) && (e.addr < CMD_ADDR_MIN);
  endfunction

endpackage

// File: rtl/rtc_init_rom.sv
// Combinational init table for the RTC: index -> {op, addr, data}.
// Entry 14 reads the status register; every other entry is a write.
module rtc_init_rom
  import rtc_bus_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output entry_t           entry
);

  always_comb begin
    entry = '0;
    case (int'(idx))
      0:       entry = mk_entry(OP_WR, 8'h02, 8'h10);
      1:       entry = mk_entry(OP_WR, 8'h02, 8'h00);
      2:       entry = mk_entry(OP_WR, 8'h10, 8'hD2);
      3:       entry = mk_entry(OP_WR, 8'h00, 8'h0A);
      4:       entry = mk_entry(OP_WR, 8'h21, 8'h00);
      5:       entry = mk_entry(OP_WR, 8'h22, 8'h00);
      6:       entry = mk_entry(OP_WR, 8'h23, 8'h03);
      7:       entry = mk_entry(OP_WR, 8'h24, 8'h26);
      8:       entry = mk_entry(OP_WR, 8'h25, 8'h04);
      9:       entry = mk_entry(OP_WR, 8'h26, 8'h16);
      10:      entry = mk_entry(OP_WR, 8'h43, 8'h23);
      11:      entry = mk_entry(OP_WR, 8'h42, 8'h58);
      12:      entry = mk_entry(OP_WR, 8'h41, 8'h59);
      13:      entry = mk_entry(OP_WR, 8'hF2, 8'hF2);
      14:      entry = mk_entry(OP_RD, 8'h01, 8'h00);
      15:      entry = mk_entry(OP_WR, 8'hF1, 8'hF1);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Plays the rtc_init_rom table over the multiplexed RTC A/D bus on one start pulse.
// Define RTC_READBACK_VERIFY_EN to read back every non-command write and flag mismatches on err_o.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int N_ENTRIES = DEF_N_ENTRIES,
  parameter int T_PULSE   = DEF_T_PULSE,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] ad_o,
  output logic              ad_oe_o,
  input  logic [DATA_W-1:0] ad_i,
  output logic              a_d_o,
  output logic              cs_n_o,
  output logic              rd_n_o,
  output logic              wr_n_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              err_o,
  output state_t            dbg_state
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0] idx, idx_nxt;
  entry_t           cur;
  logic             pulse_end, gap_end, last_entry;
  logic             ph_addr, ph_agap, ph_data, ph_dgap, rd_ph, capture;

  rtc_init_rom #(.IDX_W(IDX_W)) u_rom (.idx(idx), .entry(cur));

  assign dbg_state  = state;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign pulse_end  = (cnt == CNT_W'(T_PULSE - 1));
  assign gap_end    = (cnt == CNT_W'(T_GAP - 1));
  assign last_entry = (idx == IDX_W'(N_ENTRIES - 1));

`ifdef RTC_READBACK_VERIFY_EN
  assign ph_addr = state inside {S_ADDR, S_VERIFY_ADDR};
  assign ph_agap = state inside {S_ADDR_GAP, S_VERIFY_AGAP};
  assign ph_data = state inside {S_DATA, S_VERIFY_DATA};
  assign ph_dgap = state inside {S_DATA_GAP, S_VERIFY_DGAP};
  assign rd_ph   = (cur.op == OP_RD) || (state == S_VERIFY_DATA);
`else
  assign ph_addr = (state == S_ADDR);
  assign ph_agap = (state == S_ADDR_GAP);
  assign ph_data = (state == S_DATA);
  assign ph_dgap = (state == S_DATA_GAP);
  assign rd_ph   = (cur.op == OP_RD);
`endif

  assign capture = ph_data && rd_ph && pulse_end;

  // start_i is a request without backpressure: it is taken only in IDLE and dropped otherwise.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    idx_nxt   = idx;
    case (state)
      S_IDLE: if (start_i) begin
        state_nxt = S_ADDR;
        idx_nxt   = '0;
      end
      S_ADDR:     if (pulse_end) state_nxt = S_ADDR_GAP; else cnt_nxt = cnt_inc;
      S_ADDR_GAP: if (gap_end)   state_nxt = S_DATA;     else cnt_nxt = cnt_inc;
      S_DATA:     if (pulse_end) state_nxt = S_DATA_GAP; else cnt_nxt = cnt_inc;
      S_DATA_GAP:
        if (!gap_end) cnt_nxt = cnt_inc;
`ifdef RTC_READBACK_VERIFY_EN
        else if (needs_verify(cur)) state_nxt = S_VERIFY_ADDR;
`endif
        else if (last_entry) state_nxt = S_FINISH;
        else begin
          state_nxt = S_ADDR;
          idx_nxt   = idx + IDX_W'(1);
        end
`ifdef RTC_READBACK_VERIFY_EN
      S_VERIFY_ADDR: if (pulse_end) state_nxt = S_VERIFY_AGAP; else cnt_nxt = cnt_inc;
      S_VERIFY_AGAP: if (gap_end)   state_nxt = S_VERIFY_DATA; else cnt_nxt = cnt_inc;
      S_VERIFY_DATA: if (pulse_end) state_nxt = S_VERIFY_DGAP; else cnt_nxt = cnt_inc;
      S_VERIFY_DGAP:
        if (!gap_end) cnt_nxt = cnt_inc;
        else if (last_entry) state_nxt = S_FINISH;
        else begin
          state_nxt = S_ADDR;
          idx_nxt   = idx + IDX_W'(1);
        end
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // a_d_o only toggles inside the gaps, one cycle away from the strobe edges when T_GAP > 1.
  always_comb begin
    busy_o  = (state != S_IDLE) && (state != S_FINISH);
    done_o  = (state == S_FINISH);
    cs_n_o  = 1'b1;
    rd_n_o  = 1'b1;
    wr_n_o  = 1'b1;
    a_d_o   = 1'b0;
    ad_oe_o = 1'b0;
    ad_o    = '0;
    if (ph_addr) begin
      cs_n_o  = 1'b0;
      wr_n_o  = 1'b0;
      ad_oe_o = 1'b1;
      ad_o    = DATA_W'(cur.addr);
    end
    if (ph_agap) begin
      ad_oe_o = 1'b1;
      ad_o    = DATA_W'(cur.addr);
      a_d_o   = gap_end;
    end
    if (ph_data) begin
      a_d_o  = 1'b1;
      cs_n_o = 1'b0;
      if (rd_ph) rd_n_o = 1'b0;
      else begin
        wr_n_o  = 1'b0;
        ad_oe_o = 1'b1;
        ad_o    = DATA_W'(cur.data);
      end
    end
    if (ph_dgap) a_d_o = !gap_end;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      rd_valid_o <= capture;
      if (capture) rd_data_o <= ad_i;
    end
  end

`ifdef RTC_READBACK_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (reset) err_q <= 1'b0;
    else if (state == S_IDLE && start_i) err_q <= 1'b0;
    else if (state == S_VERIFY_DATA && pulse_end && ad_i != DATA_W'(cur.data)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
